heroe_ctrl: RTL and testbench
=============================

# heroe_ctrl

Input controller that sits directly upstream of the character ROM. It turns four raw push-buttons into the `heroe` (character select, 1–5) and `mov` (movement code) buses that the ROM decodes into 7-segment patterns. Each button is synchronized, debounced and edge-detected. A small FSM then cycles the selected hero and holds each movement for a fixed display time before returning to the hero glyph.

## Interface

**Parameters**
- `DEB_CYCLES`, default 500000: consecutive stable cycles required to accept a button level change (10 ms at 50 MHz).
- `HOLD_CYCLES`, default 25000000: cycles a movement code is held on `mov` (0.5 s at 50 MHz).

**Ports**
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `btn_sel`  in  1  raw button, advance hero; asynchronous, active-high.
- `btn_volar`  in  1  raw button, fly.
- `btn_saltar`  in  1  raw button, jump.
- `btn_agachar`  in  1  raw button, crouch.
- `heroe`  out  3  selected hero, range 1..5, registered.
- `mov`  out  2  0 = show hero, 1 = volar, 2 = saltar, 3 = agachar; registered.
- `busy`  out  1  high while a movement is being held (state MOVE).

## Operation
- **Reset values:** `heroe` = 1, `mov` = 0, `busy` = 0, FSM = IDLE, all debounced levels = 0, all counters = 0.
- **Per-button front end:**
  - 2-flop synchronizer.
  - Debouncer: the debounced level `db` takes the synchronized value only after that value has differed from `db` for exactly `DEB_CYCLES` consecutive cycles. Any cycle where they agree clears the counter.
  - Rising-edge detector on `db` produces a 1-cycle pulse `p_*`. Release edges produce nothing.
- **FSM, two states.**
  - **IDLE** (`mov` = 0, `busy` = 0):
    - A move pulse sets `mov` to its code, loads the hold counter with 0, and goes to MOVE.
    - Simultaneous move pulses resolve by priority volar > saltar > agachar.
    - `p_sel` alone, with no move pulse that cycle: `heroe` increments and wraps 5→1.
    - `p_sel` coincident with any move pulse: the move wins and the select is dropped.
  - **MOVE** (`busy` = 1):
    - The hold counter increments every cycle. When it reaches `HOLD_CYCLES`−1, the next edge sets `mov` = 0 and returns to IDLE.
    - All pulses arriving in MOVE are discarded, not queued; this includes `p_sel`.
- **Invariants:**
  - `heroe` is never 0, 6 or 7. Any illegal value (e.g. after SEU) is forced to 1 on the next edge.
  - `heroe` never changes while in MOVE.
- **Counter widths:** `$clog2(DEB_CYCLES+1)` and `$clog2(HOLD_CYCLES+1)`, unsigned, no overflow possible.
- **Reset mid-operation:** `rst_n` low forces reset values immediately, independent of `clk`. A held movement is abandoned and the debouncers restart from 0.

## Timing
- Raw button stable high → `p_*` pulse: 2 sync cycles + `DEB_CYCLES` cycles + 1 edge-detect cycle.
- `p_*` → `heroe`/`mov`/`busy` update: 1 cycle (registered outputs).
- `mov` ≠ 0 and `busy` = 1 for exactly `HOLD_CYCLES` cycles.
- A pulse arriving on the first IDLE cycle after MOVE is accepted, so back-to-back moves are separated by exactly 1 `mov` = 0 cycle.
- Glitches shorter than `DEB_CYCLES` cycles produce no pulse.
- All outputs are glitch-free flop outputs, consumed combinationally by the ROM.

## Structure
- **Shared package `heroe_pkg`:**
  - `HERO_MIN` = 1, `HERO_MAX` = 5.
  - `MOV_NONE`/`MOV_VOLAR`/`MOV_SALTAR`/`MOV_AGACHAR` = 0/1/2/3.
  - FSM state type {IDLE, MOVE}.
  - The ROM will reuse the hero and movement constants.
- **Sub-module `btn_debounce`:** synchronizer + debouncer + rise detector, parameter `DEB_CYCLES`. Ports `clk`, `rst_n`, `btn`, `level`, `pulse`. Instantiated 4×.
- **Top level:** FSM, hero counter and hold counter.

## Test plan
All scenarios use `DEB_CYCLES` = 4 and `HOLD_CYCLES` = 8.
1. **Reset, then select presses:** release reset, then press `btn_sel` 6 times (each press 10 cycles high, 10 low) → `heroe` steps 1→2→3→4→5→1→2, `mov` stays 0.
2. **Debounce:** `btn_volar` high for 3 cycles, then low → no pulse, `mov` stays 0. High for 10 cycles → `mov` = 1 exactly 2+4+1+1 = 8 cycles after the rise.
3. **Movement hold:** `btn_saltar` press → `mov` = 2 and `busy` = 1 for exactly 8 cycles, then `mov` = 0 and `busy` = 0. `btn_sel` pressed during the hold → `heroe` unchanged.
4. **Priority:** `btn_volar`, `btn_agachar` and `btn_sel` rise on the same cycle → `mov` = 1, `heroe` unchanged. A second `btn_agachar` press during MOVE → ignored, no queued move afterwards.
5. **Reset mid-move:** `rst_n` low 3 cycles into an agachar hold, asserted between clock edges → `mov` = 0, `busy` = 0, `heroe` = 1 immediately, before the next edge. After release, the first select press gives `heroe` = 2.
6. **Back-to-back:** `btn_saltar` held high through the end of a volar hold with a fresh press edge landing on the return-to-IDLE cycle → exactly one `mov` = 0 cycle, then `mov` = 2 for 8 cycles.

Source files
------------

// File: rtl/heroe_pkg.sv
// heroe_pkg: hero/movement codes and FSM state type shared by the controller and the character ROM.
package heroe_pkg;

    localparam logic [2:0] HERO_MIN = 3'd1;
    localparam logic [2:0] HERO_MAX = 3'd5;

    localparam logic [1:0] MOV_NONE    = 2'd0;
    localparam logic [1:0] MOV_VOLAR   = 2'd1;
    localparam logic [1:0] MOV_SALTAR  = 2'd2;
    localparam logic [1:0] MOV_AGACHAR = 2'd3;

    typedef enum logic {IDLE, MOVE} state_t;

    function automatic logic hero_ok(input logic [2:0] h);
        return h >= HERO_MIN && h <= HERO_MAX;
    endfunction

    function automatic logic [2:0] next_hero(input logic [2:0] h);
        return (h >= HERO_MAX || h < HERO_MIN) ? HERO_MIN : h + 3'd1;
    endfunction

endpackage

// File: rtl/heroe_ctrl_btn_debounce.sv
// btn_debounce: 2-flop synchronizer, counting debouncer and registered rise detector for one raw button.
module btn_debounce #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic level,
    output logic pulse
);

    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic          s0, s1, level_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0      <= 1'b0;
            s1      <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            pulse   <= 1'b0;
            cnt     <= '0;
        end else begin
            s0      <= btn;
            s1      <= s0;
            level_d <= level;
            pulse   <= level & ~level_d;
            // accept the new level on the DEB_CYCLES-th consecutive disagreeing cycle
            if (s1 == level)
                cnt <= '0;
            else if (cnt == CW'(DEB_CYCLES - 1)) begin
                level <= s1;
                cnt   <= '0;
            end else
                cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/heroe_ctrl.sv
// heroe_ctrl: debounced buttons drive hero selection and timed movement codes for the character ROM.
module heroe_ctrl
    import heroe_pkg::*;
#(
    parameter int DEB_CYCLES  = 500000,
    parameter int HOLD_CYCLES = 25000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_sel,
    input  logic       btn_volar,
    input  logic       btn_saltar,
    input  logic       btn_agachar,
    output logic [2:0] heroe,
    output logic [1:0] mov,
    output logic       busy
);

    localparam int HW = $clog2(HOLD_CYCLES + 1);

    logic [3:0]    lvl;
    logic          p_sel, p_volar, p_saltar, p_agachar;
    state_t        state, state_n;
    logic [2:0]    heroe_n;
    logic [1:0]    mov_n;
    logic [HW-1:0] hold, hold_n;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_sel (
        .clk(clk), .rst_n(rst_n), .btn(btn_sel), .level(lvl[0]), .pulse(p_sel));
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_volar (
        .clk(clk), .rst_n(rst_n), .btn(btn_volar), .level(lvl[1]), .pulse(p_volar));
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_saltar (
        .clk(clk), .rst_n(rst_n), .btn(btn_saltar), .level(lvl[2]), .pulse(p_saltar));
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_agachar (
        .clk(clk), .rst_n(rst_n), .btn(btn_agachar), .level(lvl[3]), .pulse(p_agachar));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            heroe <= HERO_MIN;
            mov   <= MOV_NONE;
            hold  <= '0;
        end else begin
            state <= state_n;
            heroe <= heroe_n;
            mov   <= mov_n;
            hold  <= hold_n;
        end
    end

    always_comb begin
        state_n = state;
        heroe_n = heroe;
        mov_n   = mov;
        hold_n  = hold;
        if (state == IDLE) begin
            mov_n = MOV_NONE;
            if (p_volar | p_saltar | p_agachar) begin
                state_n = MOVE;
                hold_n  = '0;
                mov_n   = p_volar ? MOV_VOLAR : p_saltar ? MOV_SALTAR : MOV_AGACHAR;
            end else if (p_sel)
                heroe_n = next_hero(heroe);
        end else if (hold == HW'(HOLD_CYCLES - 1)) begin
            state_n = IDLE;
            mov_n   = MOV_NONE;
            hold_n  = '0;
        end else
            hold_n = hold + HW'(1);
        // an upset-corrupted hero code is repaired regardless of state
        if (!hero_ok(heroe))
            heroe_n = HERO_MIN;
    end

    assign busy = (state == MOVE);

endmodule

// File: tb/tb_heroe_ctrl.sv
// tb_heroe_ctrl: scenario tasks with a scoreboard of expected movement starts checked by a negedge monitor.
module tb_heroe_ctrl;

    typedef struct {
        int         cyc;
        logic [1:0] mov;
        logic [2:0] hero;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       btn_sel = 1'b0, btn_volar = 1'b0, btn_saltar = 1'b0, btn_agachar = 1'b0;
    logic [2:0] heroe;
    logic [1:0] mov;
    logic       busy;

    int         checks = 0, failures = 0, cyc = 0, run = 0;
    logic [1:0] prev_mov = 2'd0;
    logic [2:0] exp_hero = 3'd1;
    exp_t       q[$];
    exp_t       e;

    heroe_ctrl #(.DEB_CYCLES(4), .HOLD_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n), .btn_sel(btn_sel), .btn_volar(btn_volar),
        .btn_saltar(btn_saltar), .btn_agachar(btn_agachar),
        .heroe(heroe), .mov(mov), .busy(busy));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // movement starts pop the scoreboard; movement ends check the hold length
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_mov = 2'd0;
            run = 0;
        end else begin
            checks++;
            if (busy !== (mov != 2'd0)) begin
                failures++;
                $display("FAIL busy_vs_mov cyc=%0d busy=%b mov=%0d", cyc, busy, mov);
            end
            if (mov != 2'd0 && mov !== prev_mov) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_move cyc=%0d mov=%0d heroe=%0d", cyc, mov, heroe);
                end else begin
                    e = q.pop_front();
                    if (mov !== e.mov || cyc != e.cyc || heroe !== e.hero) begin
                        failures++;
                        $display("FAIL move_start got mov=%0d cyc=%0d heroe=%0d expected mov=%0d cyc=%0d heroe=%0d",
                                 mov, cyc, heroe, e.mov, e.cyc, e.hero);
                    end
                end
                run = 1;
            end else if (mov != 2'd0)
                run++;
            else if (prev_mov != 2'd0) begin
                checks++;
                if (run != 8) begin
                    failures++;
                    $display("FAIL hold_length got=%0d expected=8", run);
                end
            end
            prev_mov = mov;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((q.size() != 0 || mov != 2'd0) && n < 200) begin
            tick(1);
            n++;
        end
        checks++;
        if (n >= 200) begin
            failures++;
            $display("FAIL wait_idle_timeout pending=%0d mov=%0d", q.size(), mov);
        end
        tick(20);
    endtask

    task automatic press_sel();
        btn_sel = 1'b1;
        tick(10);
        btn_sel = 1'b0;
        tick(10);
        exp_hero = (exp_hero == 3'd5) ? 3'd1 : exp_hero + 3'd1;
        checks++;
        if (heroe !== exp_hero) begin
            failures++;
            $display("FAIL sel_step got heroe=%0d expected=%0d", heroe, exp_hero);
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        checks++;
        if (heroe !== 3'd1 || mov !== 2'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_values got heroe=%0d mov=%0d busy=%b expected 1 0 0", heroe, mov, busy);
        end
        tick(3);
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_select();
        for (int i = 0; i < 6; i++) begin
            press_sel();
            checks++;
            if (mov !== 2'd0) begin
                failures++;
                $display("FAIL sel_mov got mov=%0d expected=0", mov);
            end
        end
    endtask

    task automatic test_debounce();
        btn_volar = 1'b1;
        tick(3);
        btn_volar = 1'b0;
        tick(15);
        checks++;
        if (mov !== 2'd0) begin
            failures++;
            $display("FAIL glitch got mov=%0d expected=0", mov);
        end
        q.push_back('{cyc + 8, 2'd1, exp_hero});
        btn_volar = 1'b1;
        tick(10);
        btn_volar = 1'b0;
        wait_idle();
    endtask

    task automatic test_hold();
        q.push_back('{cyc + 8, 2'd2, exp_hero});
        btn_saltar = 1'b1;
        tick(3);
        btn_sel = 1'b1;
        tick(7);
        btn_saltar = 1'b0;
        btn_sel = 1'b0;
        wait_idle();
        checks++;
        if (heroe !== exp_hero) begin
            failures++;
            $display("FAIL sel_in_move got heroe=%0d expected=%0d", heroe, exp_hero);
        end
    endtask

    task automatic test_priority();
        q.push_back('{cyc + 8, 2'd1, exp_hero});
        btn_volar = 1'b1;
        btn_agachar = 1'b1;
        btn_sel = 1'b1;
        tick(4);
        btn_volar = 1'b0;
        btn_agachar = 1'b0;
        btn_sel = 1'b0;
        tick(4);
        // this second press pulses exactly on the final MOVE cycle
        btn_agachar = 1'b1;
        tick(10);
        btn_agachar = 1'b0;
        wait_idle();
        checks++;
        if (heroe !== exp_hero || mov !== 2'd0) begin
            failures++;
            $display("FAIL priority_after got heroe=%0d mov=%0d expected heroe=%0d mov=0", heroe, mov, exp_hero);
        end
    endtask

    task automatic test_reset_mid_move();
        int n = 0;
        q.push_back('{cyc + 8, 2'd3, exp_hero});
        btn_agachar = 1'b1;
        while (mov !== 2'd3 && n < 30) begin
            tick(1);
            n++;
        end
        checks++;
        if (n >= 30) begin
            failures++;
            $display("FAIL agachar_start_timeout mov=%0d", mov);
        end
        tick(3);
        rst_n = 1'b0;
        #1;
        checks++;
        if (mov !== 2'd0 || busy !== 1'b0 || heroe !== 3'd1) begin
            failures++;
            $display("FAIL async_reset got mov=%0d busy=%b heroe=%0d expected 0 0 1", mov, busy, heroe);
        end
        btn_agachar = 1'b0;
        tick(3);
        rst_n = 1'b1;
        exp_hero = 3'd1;
        tick(10);
        press_sel();
    endtask

    task automatic test_back_to_back();
        q.push_back('{cyc + 8, 2'd1, exp_hero});
        btn_volar = 1'b1;
        tick(9);
        q.push_back('{cyc + 8, 2'd2, exp_hero});
        btn_saltar = 1'b1;
        tick(1);
        btn_volar = 1'b0;
        tick(11);
        btn_saltar = 1'b0;
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_select();
        test_debounce();
        test_hold();
        test_priority();
        test_reset_mid_move();
        test_back_to_back();
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover got=%0d expected=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
